// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   state_t        : transfer FSM states (idle, byte transfer, completion)
//   REQ_CPU/REQ_DBG: requester identifiers, also used as req[] bit positions
//   BYTES_PER_WORD : byte cycles per word access
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic (purely combinational).
//   req[1:0]  : request vector, bit REQ_CPU = processor, bit REQ_DBG = debug
//   last_gnt  : requester granted most recently (state held by the parent)
//   gnt_valid : at least one request present
//   gnt_id    : requester to grant; on contention, the one not granted last
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = REQ_CPU;
        if (req[REQ_CPU] && req[REQ_DBG]) begin
            gnt_id = ~last_gnt;
        end else if (req[REQ_DBG]) begin
            gnt_id = REQ_DBG;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a byte-wide data memory between the processor load/store path and
// a debug/loader port. Each granted word access runs as four byte cycles,
// big-endian (byte at addr carries bits 31:24), followed by a one-cycle
// done pulse to the granted requester.
//   clk, rst                     : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata        : processor request, held until cpu_done
//   cpu_rdata, cpu_done          : processor read word and completion pulse
//   dbg_*                        : same set for the debug/loader port
//   mem_addr/we/wdata, mem_rdata : byte interface to the memory array
//   busy                         : transfer or completion in progress
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic              busy
);

    state_t                  state_reg, state_next;
    logic [BYTE_CNT_W-1:0]   byte_cnt_reg;
    logic                    last_gnt_reg;
    logic                    gnt_id_reg;
    logic                    we_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [DATA_W-1:0]       rdata_sr_reg;
    logic [DATA_W-1:0]       cpu_rdata_reg;
    logic [DATA_W-1:0]       dbg_rdata_reg;

    logic                    gnt_valid;
    logic                    gnt_id;
    logic                    last_byte;
    logic [DATA_W-1:0]       rdata_sr_next;
    logic [BYTE_W-1:0]       wbyte [BYTES_PER_WORD];

    rr_arbiter2 u_arb (
        .req       ({dbg_req, cpu_req}),
        .last_gnt  (last_gnt_reg),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Split the latched write word into bytes, most significant first.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_wbyte
            assign wbyte[gi] = wdata_reg[DATA_W-1-BYTE_W*gi -: BYTE_W];
        end
    endgenerate

    assign last_byte     = (byte_cnt_reg == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign rdata_sr_next = {rdata_sr_reg[DATA_W-BYTE_W-1:0], mem_rdata};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (gnt_valid) state_next = ST_XFER;
            ST_XFER: if (last_byte) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch, byte counter and read assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_reg  <= REQ_DBG;   // cpu wins the first contention
            gnt_id_reg    <= REQ_CPU;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            byte_cnt_reg  <= '0;
            rdata_sr_reg  <= '0;
            cpu_rdata_reg <= '0;
            dbg_rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    byte_cnt_reg <= '0;
                    if (gnt_valid) begin
                        gnt_id_reg   <= gnt_id;
                        last_gnt_reg <= gnt_id;
                        if (gnt_id == REQ_DBG) begin
                            we_reg    <= dbg_we;
                            addr_reg  <= dbg_addr;
                            wdata_reg <= dbg_wdata;
                        end else begin
                            we_reg    <= cpu_we;
                            addr_reg  <= cpu_addr;
                            wdata_reg <= cpu_wdata;
                        end
                    end
                end
                ST_XFER: begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                    if (!we_reg) begin
                        rdata_sr_reg <= rdata_sr_next;
                        // Publish the finished word so it is valid during done
                        if (last_byte) begin
                            if (gnt_id_reg == REQ_DBG) begin
                                dbg_rdata_reg <= rdata_sr_next;
                            end else begin
                                cpu_rdata_reg <= rdata_sr_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        cpu_done  = 1'b0;
        dbg_done  = 1'b0;
        busy      = 1'b0;
        case (state_reg)
            ST_XFER: begin
                busy     = 1'b1;
                mem_addr = addr_reg + ADDR_W'(byte_cnt_reg);  // wraps mod depth
                mem_we   = we_reg;
                if (we_reg) mem_wdata = wbyte[byte_cnt_reg];
            end
            ST_DONE: begin
                busy     = 1'b1;
                cpu_done = (gnt_id_reg == REQ_CPU);
                dbg_done = (gnt_id_reg == REQ_DBG);
            end
            default: ;
        endcase
    end

    assign cpu_rdata = cpu_rdata_reg;
    assign dbg_rdata = dbg_rdata_reg;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [4:0]  cpu_addr, dbg_addr;
    logic [31:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata;
    logic        cpu_done, dbg_done;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    dmem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // The datmem array the arbiter drives
    logic [7:0] mem [32];
    bit         mem_ready;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 37 + 11);
            mem_ready <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reference model state
    logic [7:0]  mm [32];
    logic [31:0] exp_cpu_rd, exp_dbg_rd;
    bit          model_last;   // 0 = cpu granted last, 1 = dbg
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        bit          port;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [4:0] a);
        logic [31:0] w = 0;
        for (int i = 0; i < 4; i++) w = (w << 8) | 32'(mm[(int'(a) + i) % 32]);
        return w;
    endfunction

    task automatic model_write(input logic [4:0] a, input logic [31:0] wd);
        for (int i = 0; i < 4; i++) mm[(int'(a) + i) % 32] = 8'((wd >> (24 - 8 * i)) & 32'hFF);
    endtask

    task automatic check_mem(input string name);
        int bad = -1;
        for (int i = 0; i < 32; i++) if (mem[i] !== mm[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: mem[%0d] got %h expected %h", name, bad, mem[bad], mm[bad]);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_done && !dbg_done && n < 20);
    endtask

    // One single-port word transaction with cycle-by-cycle checks
    task automatic do_txn(input bit port, input bit we, input logic [4:0] a,
                          input logic [31:0] wd, input bit has_exp, input logic [31:0] exp_rd);
        @(negedge clk);
        if (port) begin
            dbg_we = we; dbg_addr = a; dbg_wdata = wd; dbg_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("busy_xfer", 32'(busy), 32'd1);
            chk("mem_addr", 32'(mem_addr), 32'((int'(a) + k) % 32));
            chk("mem_we", 32'(mem_we), 32'(we));
            if (we) chk("mem_wdata", 32'(mem_wdata), (wd >> (24 - 8 * k)) & 32'hFF);
            chk("done_early", 32'({cpu_done, dbg_done}), 32'd0);
        end
        @(negedge clk);
        if (we) model_write(a, wd);
        else if (port) exp_dbg_rd = model_word(a);
        else exp_cpu_rd = model_word(a);
        chk("done_own", 32'(port ? dbg_done : cpu_done), 32'd1);
        chk("done_other", 32'(port ? cpu_done : dbg_done), 32'd0);
        chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
        chk("dbg_rdata", dbg_rdata, exp_dbg_rd);
        if (has_exp) chk("rdata_vec", port ? dbg_rdata : cpu_rdata, exp_rd);
        if (port) dbg_req = 1'b0; else cpu_req = 1'b0;
        model_last = port;
        @(negedge clk);
        chk("done_pulse", 32'({cpu_done, dbg_done}), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        if (we) check_mem("mem_after_write");
        $display("txn port=%s we=%0d addr=%0d wdata=%h cpu_rdata=%h dbg_rdata=%h",
                 port ? "dbg" : "cpu", we, a, wd, cpu_rdata, dbg_rdata);
    endtask

    initial begin
        int n;
        bit exp_port;

        for (int i = 0; i < 32; i++) mm[i] = 8'(i * 37 + 11);
        exp_cpu_rd = 0; exp_dbg_rd = 0; model_last = 1'b1;

        tbl[0] = '{0, 1, 5'd4,  32'hDEADBEEF, 0, 32'h0};
        tbl[1] = '{1, 0, 5'd4,  32'h0,        1, 32'hDEADBEEF};
        tbl[2] = '{1, 1, 5'd2,  32'h99AABBCC, 0, 32'h0};
        tbl[3] = '{0, 1, 5'd30, 32'h11223344, 0, 32'h0};
        tbl[4] = '{1, 1, 5'd26, 32'h55667788, 0, 32'h0};
        tbl[5] = '{0, 0, 5'd28, 32'h0,        1, 32'h77881122};
        tbl[6] = '{0, 0, 5'd4,  32'h0,        1, 32'hBBCCBEEF};
        tbl[7] = '{1, 0, 5'd31, 32'h0,        1, 32'h22334499};

        // Reset held with both requests pending
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd0;  cpu_wdata = 0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd16; dbg_wdata = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_done", 32'({cpu_done, dbg_done}), 32'd0);
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_rdata", cpu_rdata | dbg_rdata, 32'd0);
        end
        rst = 1'b0;
        wait_done(n);
        chk("first_grant_latency", 32'(n), 32'd5);
        chk("first_grant_cpu", 32'({cpu_done, dbg_done}), 32'b10);
        exp_cpu_rd = model_word(5'd0);
        chk("first_cpu_rdata", cpu_rdata, exp_cpu_rd);
        cpu_req = 1'b0; dbg_req = 1'b0; model_last = 1'b0;
        $display("txn reset-contention port=cpu we=0 addr=0 cpu_rdata=%h", cpu_rdata);
        @(negedge clk);
        chk("post_first_idle", 32'(busy), 32'd0);

        // Table-driven single-port transactions
        for (int v = 0; v < 8; v++)
            do_txn(tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].wdata, tbl[v].chk_rd, tbl[v].exp_rd);

        // Both ports requesting continuously for three transactions
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 5'd12; cpu_wdata = 32'h01020304; cpu_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 5'd12; dbg_req = 1'b1;
        for (int t = 0; t < 3; t++) begin
            wait_done(n);
            exp_port = ~model_last;
            chk("contend_spacing", 32'(n), (t == 0) ? 32'd5 : 32'd6);
            chk("contend_overlap", 32'(cpu_done & dbg_done), 32'd0);
            chk("contend_winner", 32'({cpu_done, dbg_done}), exp_port ? 32'b01 : 32'b10);
            if (exp_port) exp_dbg_rd = model_word(5'd12);
            else model_write(5'd12, 32'h01020304);
            chk("contend_cpu_rdata", cpu_rdata, exp_cpu_rd);
            chk("contend_dbg_rdata", dbg_rdata, exp_dbg_rd);
            model_last = exp_port;
            $display("txn contention #%0d winner=%s dbg_rdata=%h", t, exp_port ? "dbg" : "cpu", dbg_rdata);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        check_mem("contend_mem");

        // Reset during the second byte cycle of a write
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 5'd8; cpu_wdata = 32'hAABBCCDD; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_addr", 32'(mem_addr), 32'd9);
        rst = 1'b1; cpu_req = 1'b0;
        @(negedge clk);
        mm[8] = 8'hAA; mm[9] = 8'hBB;
        model_last = 1'b1; exp_cpu_rd = 0; exp_dbg_rd = 0;
        chk("abort_state", 32'({busy, mem_we, cpu_done, dbg_done}), 32'd0);
        chk("abort_rdata", cpu_rdata | dbg_rdata, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", 32'({busy, cpu_done, dbg_done}), 32'd0);
        end
        check_mem("abort_partial_write");
        $display("txn aborted write addr=8 mem[8..11]=%h %h %h %h", mem[8], mem[9], mem[10], mem[11]);

        // Randomized single-port traffic
        for (int r = 0; r < 30; r++)
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, 1'b0, 32'h0);
        check_mem("final_mem");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
